// File: rtl/mib_master_burst.sv
`default_nettype none
// ============================================================================
// Module   : mib_master_burst
// Purpose  : Command-bus to MIB bus master. A single command transaction
//            (sel / rd_wr_n / byte_addr / wdata -> ack / rdata) is expanded
//            into a multi-phase MIB sequence: address words, optional write
//            data words, a turnaround cycle, an ACK wait and, for reads, the
//            returned data words. A missing ACK ends an attempt after
//            P_MIB_ACK_TIMEOUT_CLKS cycles; up to P_MAX_RETRIES further
//            attempts are made before the transaction is abandoned.
// Ports    : i_sysclk / i_srst_n        clock, synchronous active-low reset
//            i_cmd_*  / o_cmd_*         command-bus request and completion
//            o_busy, o_timeout_cnt      status
//            i_mib_ad, i_mib_slave_ack  MIB inputs from the board AD bus
//            o_mib_*                    MIB outputs (start, direction,
//                                       AD value, AD tri-state control)
// Revision : 1.0 - initial release
// ============================================================================
module mib_master_burst #(
  parameter int ADDR_BITS              = 24,
  parameter int DATA_BITS              = 32,
  parameter int MIB_AD_BITS            = 16,
  parameter int P_MIB_ACK_TIMEOUT_CLKS = 32,
  parameter int P_MAX_RETRIES          = 1
) (
  input  logic                   i_sysclk,
  input  logic                   i_srst_n,
  input  logic                   i_cmd_sel,
  input  logic                   i_cmd_rd_wr_n,
  input  logic [ADDR_BITS-1:0]   i_cmd_byte_addr,
  input  logic [DATA_BITS-1:0]   i_cmd_wdata,
  output logic                   o_cmd_ack,
  output logic [DATA_BITS-1:0]   o_cmd_rdata,
  output logic                   o_cmd_mib_timeout,
  output logic                   o_busy,
  output logic [15:0]            o_timeout_cnt,
  input  logic [MIB_AD_BITS-1:0] i_mib_ad,
  input  logic                   i_mib_slave_ack,
  output logic                   o_mib_start,
  output logic                   o_mib_rd_wr_n,
  output logic                   o_mib_ad_high_z,
  output logic [MIB_AD_BITS-1:0] o_mib_ad
);

  localparam int ADDR_PHASES   = (ADDR_BITS + MIB_AD_BITS - 1) / MIB_AD_BITS;
  localparam int DATA_PHASES   = DATA_BITS / MIB_AD_BITS;
  localparam int ADDR_EXT_BITS = ADDR_PHASES * MIB_AD_BITS;
  localparam int PH_MAX        = (ADDR_PHASES > DATA_PHASES) ? ADDR_PHASES : DATA_PHASES;
  localparam int PH_W          = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TMR_W         = $clog2(P_MIB_ACK_TIMEOUT_CLKS);
  localparam int RTY_W         = (P_MAX_RETRIES > 0) ? $clog2(P_MAX_RETRIES + 1) : 1;

  localparam logic [PH_W-1:0]  ADDR_LAST = PH_W'(ADDR_PHASES - 1);
  localparam logic [PH_W-1:0]  DATA_LAST = PH_W'(DATA_PHASES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(P_MIB_ACK_TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_TURN  = 3'd3,
    S_WAIT  = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6,
    S_TOUT  = 3'd7
  } state_t;

  // Word p of a multi-word value, counted from the most significant word.
  function automatic logic [MIB_AD_BITS-1:0] addr_word(input logic [ADDR_EXT_BITS-1:0] a,
                                                       input logic [PH_W-1:0] p);
    logic [ADDR_EXT_BITS-1:0] s;
    s = a >> (MIB_AD_BITS * (ADDR_PHASES - 1 - int'(p)));
    return s[MIB_AD_BITS-1:0];
  endfunction

  function automatic logic [MIB_AD_BITS-1:0] data_word(input logic [DATA_BITS-1:0] d,
                                                       input logic [PH_W-1:0] p);
    logic [DATA_BITS-1:0] s;
    s = d >> (MIB_AD_BITS * (DATA_PHASES - 1 - int'(p)));
    return s[MIB_AD_BITS-1:0];
  endfunction

  // Control state
  state_t                   state_q,   state_d;
  logic [PH_W-1:0]          phase_q,   phase_d;
  logic [TMR_W-1:0]         timer_q,   timer_d;
  logic [RTY_W-1:0]         retries_q, retries_d;
  logic                     rw_q,      rw_d;
  logic [ADDR_EXT_BITS-1:0] addr_q,    addr_d;
  logic [DATA_BITS-1:0]     wdata_q,   wdata_d;
  logic [DATA_BITS-1:0]     shadow_q,  shadow_d;
  logic [15:0]              tcnt_q,    tcnt_d;

  // Registered outputs
  logic                     start_q,   start_d;
  logic                     rdwrn_q,   rdwrn_d;
  logic                     highz_q,   highz_d;
  logic [MIB_AD_BITS-1:0]   ad_q,      ad_d;
  logic                     ack_q,     ack_d;
  logic                     tout_q,    tout_d;
  logic                     busy_q,    busy_d;
  logic [DATA_BITS-1:0]     rdata_q,   rdata_d;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    timer_d   = timer_q;
    retries_d = retries_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shadow_d  = shadow_q;
    tcnt_d    = tcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_sel) begin
          rw_d      = i_cmd_rd_wr_n;
          addr_d    = ADDR_EXT_BITS'(i_cmd_byte_addr);
          wdata_d   = i_cmd_wdata;
          retries_d = RTY_W'(P_MAX_RETRIES);
          phase_d   = '0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (phase_q == ADDR_LAST) begin
          phase_d = '0;
          state_d = rw_q ? S_TURN : S_WDATA;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_WDATA: begin
        if (phase_q == DATA_LAST) begin
          phase_d = '0;
          state_d = S_TURN;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_TURN: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_mib_slave_ack) begin
          if (rw_q) begin
            // Read words are shifted in from the bottom; after DATA_PHASES
            // captures the first word returned sits in the MS position.
            shadow_d = (shadow_q << MIB_AD_BITS) | DATA_BITS'(i_mib_ad);
            if (DATA_PHASES == 1) begin
              state_d = S_DONE;
            end else begin
              phase_d = PH_W'(1);
              state_d = S_RDATA;
            end
          end else begin
            state_d = S_DONE;
          end
        end else if (timer_q == TMR_LAST) begin
          timer_d = '0;
          if (retries_q != '0) begin
            retries_d = retries_q - RTY_W'(1);
            phase_d   = '0;
            state_d   = S_ADDR;
          end else begin
            state_d = S_TOUT;
            if (tcnt_q != 16'hFFFF) begin
              tcnt_d = tcnt_q + 16'd1;
            end
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RDATA: begin
        shadow_d = (shadow_q << MIB_AD_BITS) | DATA_BITS'(i_mib_ad);
        if (phase_q == DATA_LAST) begin
          phase_d = '0;
          state_d = S_DONE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_TOUT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values are derived from the next state so every output is a flop
  // that lines up with the state it describes.
  always_comb begin
    start_d = (state_d == S_ADDR) && (phase_d == '0);
    highz_d = !((state_d == S_ADDR) || (state_d == S_WDATA));
    ad_d    = '0;
    if (state_d == S_ADDR) begin
      ad_d = addr_word(addr_d, phase_d);
    end else if (state_d == S_WDATA) begin
      ad_d = data_word(wdata_d, phase_d);
    end
    rdwrn_d = (state_d == S_IDLE) ? 1'b1 : rw_d;
    ack_d   = (state_d == S_DONE);
    tout_d  = (state_d == S_TOUT);
    busy_d  = (state_d != S_IDLE);
    rdata_d = rdata_q;
    if ((state_d == S_DONE) && rw_q) begin
      rdata_d = shadow_d;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      timer_q   <= '0;
      retries_q <= '0;
      rw_q      <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      shadow_q  <= '0;
      tcnt_q    <= '0;
      start_q   <= 1'b0;
      rdwrn_q   <= 1'b1;
      highz_q   <= 1'b1;
      ad_q      <= '0;
      ack_q     <= 1'b0;
      tout_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      shadow_q  <= shadow_d;
      tcnt_q    <= tcnt_d;
      start_q   <= start_d;
      rdwrn_q   <= rdwrn_d;
      highz_q   <= highz_d;
      ad_q      <= ad_d;
      ack_q     <= ack_d;
      tout_q    <= tout_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_cmd_ack         = ack_q;
  assign o_cmd_rdata       = rdata_q;
  assign o_cmd_mib_timeout = tout_q;
  assign o_busy            = busy_q;
  assign o_timeout_cnt     = tcnt_q;
  assign o_mib_start       = start_q;
  assign o_mib_rd_wr_n     = rdwrn_q;
  assign o_mib_ad_high_z   = highz_q;
  assign o_mib_ad          = ad_q;

endmodule
`default_nettype wire

// File: tb/tb_mib_master_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_mib_master_burst
// Purpose  : Self-checking bench for mib_master_burst with default parameters.
//            A vector table describes each transaction and the slave
//            behaviour; expected AD words go into a scoreboard queue when the
//            command is issued and are popped as the master drives the bus.
//            Hand-written sequences cover reset values and reset mid-read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mib_master_burst;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int MW = 16;
  localparam int NR = 1;

  logic          clk = 1'b0;
  logic          srst_n;
  logic          cmd_sel;
  logic          cmd_rd_wr_n;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_ack;
  logic [DW-1:0] cmd_rdata;
  logic          cmd_to;
  logic          busy;
  logic [15:0]   tcnt;
  logic [MW-1:0] mib_ad_in;
  logic          slave_ack;
  logic          mib_start;
  logic          mib_rdwrn;
  logic          mib_highz;
  logic [MW-1:0] mib_ad_out;

  always #5 clk = ~clk;

  mib_master_burst dut (
    .i_sysclk          (clk),
    .i_srst_n          (srst_n),
    .i_cmd_sel         (cmd_sel),
    .i_cmd_rd_wr_n     (cmd_rd_wr_n),
    .i_cmd_byte_addr   (cmd_addr),
    .i_cmd_wdata       (cmd_wdata),
    .o_cmd_ack         (cmd_ack),
    .o_cmd_rdata       (cmd_rdata),
    .o_cmd_mib_timeout (cmd_to),
    .o_busy            (busy),
    .o_timeout_cnt     (tcnt),
    .i_mib_ad          (mib_ad_in),
    .i_mib_slave_ack   (slave_ack),
    .o_mib_start       (mib_start),
    .o_mib_rd_wr_n     (mib_rdwrn),
    .o_mib_ad_high_z   (mib_highz),
    .o_mib_ad          (mib_ad_out)
  );

  // ack_att: attempt index (0-based) on which the slave answers; >NR = never.
  // sel2_cyc: cycle in which a second (to be ignored) sel is pulsed, 0 = none.
  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wait_cyc;
    int            ack_att;
    logic [MW-1:0] rd_hi;
    logic [MW-1:0] rd_lo;
    int            sel2_cyc;
  } vec_t;

  vec_t          vecs[8];
  logic [MW-1:0] exp_ad_q[$];
  logic [DW-1:0] mdl_rdata;
  logic [15:0]   mdl_tcnt;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_high_z",      64'(mib_highz),  64'd1);
    check("rst_start",       64'(mib_start),  64'd0);
    check("rst_ad",          64'(mib_ad_out), 64'd0);
    check("rst_rd_wr_n",     64'(mib_rdwrn),  64'd1);
    check("rst_ack",         64'(cmd_ack),    64'd0);
    check("rst_timeout",     64'(cmd_to),     64'd0);
    check("rst_busy",        64'(busy),       64'd0);
    check("rst_rdata",       64'(cmd_rdata),  64'd0);
    check("rst_timeout_cnt", 64'(tcnt),       64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int            l_att   = v.rw ? 35 : 37;  // cycles per failed attempt
    int            ws      = v.rw ? 3 : 5;    // first WAIT_ACK offset from start
    bit            ok      = (v.ack_att <= NR);
    int            att     = ok ? v.ack_att + 1 : NR + 1;
    int            exp_ack = ok ? 1 + v.ack_att * l_att + ws + v.wait_cyc + (v.rw ? 2 : 1) : -1;
    int            exp_to  = ok ? -1 : 1 + att * l_att;
    int            end_cyc = ok ? exp_ack : exp_to;
    int            n_start = 0;
    int            n_ack   = 0;
    int            n_to    = 0;
    int            k;
    int            off;
    logic [31:0]   a_ext;

    a_ext = {8'h00, v.addr};
    for (int a = 0; a < att; a++) begin
      exp_ad_q.push_back(a_ext[31:16]);
      exp_ad_q.push_back(a_ext[15:0]);
      if (!v.rw) begin
        exp_ad_q.push_back(v.wdata[31:16]);
        exp_ad_q.push_back(v.wdata[15:0]);
      end
    end

    cmd_rd_wr_n = v.rw;
    cmd_addr    = v.addr;
    cmd_wdata   = v.wdata;
    cmd_sel     = 1'b1;
    slave_ack   = 1'b0;
    mib_ad_in   = 16'h5A5A;
    tick();
    cmd_sel     = 1'b0;
    cmd_rd_wr_n = ~v.rw;
    cmd_addr    = ~v.addr;
    cmd_wdata   = ~v.wdata;

    for (int c = 1; c <= end_cyc + 2; c++) begin
      check("busy", 64'(busy), 64'(c <= end_cyc));
      if (!mib_highz) begin
        check("rd_wr_n", 64'(mib_rdwrn), 64'(v.rw));
        if (exp_ad_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ad_word: actual=%0h expected=none at cycle %0d", mib_ad_out, c);
        end else begin
          check("ad_word", 64'(mib_ad_out), 64'(exp_ad_q.pop_front()));
        end
      end
      if (mib_start) begin
        check("start_cycle", 64'(c), 64'(1 + n_start * l_att));
        n_start++;
      end
      if (cmd_ack) begin
        n_ack++;
        check("ack_cycle", 64'(c), 64'(exp_ack));
        if (v.rw) check("rdata_at_ack", 64'(cmd_rdata), 64'({v.rd_hi, v.rd_lo}));
      end
      if (cmd_to) begin
        n_to++;
        check("timeout_cycle", 64'(c), 64'(exp_to));
      end

      // Slave model driven from the bench's own schedule of attempts.
      k         = (c - 1) / l_att;
      off       = (c - 1) % l_att;
      slave_ack = 1'b0;
      mib_ad_in = 16'h5A5A;
      if (k == v.ack_att && off == ws + v.wait_cyc) begin
        slave_ack = 1'b1;
        mib_ad_in = v.rd_hi;
      end else if (k == v.ack_att && v.rw && off == ws + v.wait_cyc + 1) begin
        mib_ad_in = v.rd_lo;
      end
      cmd_sel = (c == v.sel2_cyc);
      tick();
    end
    cmd_sel   = 1'b0;
    slave_ack = 1'b0;

    if (ok && v.rw) mdl_rdata = {v.rd_hi, v.rd_lo};
    if (!ok && mdl_tcnt != 16'hFFFF) mdl_tcnt = mdl_tcnt + 16'd1;
    check("start_count",   64'(n_start),         64'(att));
    check("ack_count",     64'(n_ack),           64'(ok ? 1 : 0));
    check("timeout_count", 64'(n_to),            64'(ok ? 0 : 1));
    check("ad_queue_left", 64'(exp_ad_q.size()), 64'd0);
    check("rdata_hold",    64'(cmd_rdata),       64'(mdl_rdata));
    check("timeout_cnt",   64'(tcnt),            64'(mdl_tcnt));
    exp_ad_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rw    addr         wdata         wait att rd_hi     rd_lo     sel2
    vecs[0] = '{1'b0, 24'h000004, 32'h01010202, 0,   0,  16'h0000, 16'h0000, 0};
    vecs[1] = '{1'b1, 24'h000008, 32'h00000000, 5,   0,  16'hCAFE, 16'hBABE, 0};
    vecs[2] = '{1'b1, 24'h123456, 32'h00000000, 0,   0,  16'h1111, 16'h2222, 0};
    vecs[3] = '{1'b0, 24'hABCDEF, 32'hDEADBEEF, 3,   0,  16'h0000, 16'h0000, 0};
    vecs[4] = '{1'b1, 24'h00F00D, 32'h00000000, 0,   2,  16'h3333, 16'h4444, 0};
    vecs[5] = '{1'b0, 24'h0A0B0C, 32'h55AA33CC, 2,   1,  16'h0000, 16'h0000, 0};
    vecs[6] = '{1'b0, 24'h000100, 32'h87654321, 0,   0,  16'h0000, 16'h0000, 3};
    vecs[7] = '{1'b0, 24'hFFFFFF, 32'hFFFF0000, 0,   2,  16'h0000, 16'h0000, 0};

    mdl_rdata   = '0;
    mdl_tcnt    = '0;
    srst_n      = 1'b0;
    cmd_sel     = 1'b0;
    cmd_rd_wr_n = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    slave_ack   = 1'b0;
    mib_ad_in   = '0;
    repeat (3) tick();
    check_reset_outputs();
    srst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Reset asserted while the second read word is being captured.
    cmd_rd_wr_n = 1'b1;
    cmd_addr    = 24'h000010;
    cmd_sel     = 1'b1;
    tick();
    cmd_sel = 1'b0;
    repeat (3) tick();
    slave_ack = 1'b1;
    mib_ad_in = 16'h1234;
    tick();
    slave_ack = 1'b0;
    mib_ad_in = 16'h5678;
    check("busy_in_rdata", 64'(busy), 64'd1);
    srst_n = 1'b0;
    tick();
    check_reset_outputs();
    srst_n    = 1'b1;
    mdl_rdata = '0;
    mdl_tcnt  = '0;
    exp_ad_q.delete();
    repeat (2) tick();
    run_vec('{1'b1, 24'h000020, 32'h00000000, 1, 0, 16'h9ABC, 16'hDEF0, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
